// File: rtl/rom_ctrl_check_fsm_if.sv
// Bus bundle between the ROM integrity checker (master) and its ROM, KMAC and
// system environment (slave).
interface rom_ctrl_check_fsm_if #(
    parameter int unsigned RomDepth  = 16,
    parameter int unsigned TopCount  = 8,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned AW = (RomDepth > 1) ? $clog2(RomDepth) : 1;

    logic                            recheck_req;
    logic                            rom_req;
    logic [AW-1:0]                   rom_addr;
    logic [DataWidth-1:0]            rom_data;
    logic                            kmac_rom_vld;
    logic                            kmac_rom_rdy;
    logic [DataWidth-1:0]            kmac_rom_data;
    logic                            kmac_rom_last;
    logic                            kmac_done;
    logic                            kmac_err;
    logic [TopCount*DataWidth-1:0]   kmac_digest;
    logic                            bus_sel;
    logic                            done;
    logic                            good;
    logic [7:0]                      check_count;
    logic                            alert;

    modport master (
        input  recheck_req, rom_data, kmac_rom_rdy, kmac_done, kmac_err, kmac_digest,
        output rom_req, rom_addr, kmac_rom_vld, kmac_rom_data, kmac_rom_last,
               bus_sel, done, good, check_count, alert
    );

    modport slave (
        output recheck_req, rom_data, kmac_rom_rdy, kmac_done, kmac_err, kmac_digest,
        input  rom_req, rom_addr, kmac_rom_vld, kmac_rom_data, kmac_rom_last,
               bus_sel, done, good, check_count, alert
    );
endinterface

// File: rtl/rom_ctrl_check_fsm.sv
// ROM integrity checker: streams low ROM to KMAC, snoops the top digest words and compares.
// Optional re-check after Done is enabled by defining ROM_CTRL_CHECK_RECHECK_EN.
module rom_ctrl_check_fsm #(
    parameter int unsigned RomDepth  = 16,
    parameter int unsigned TopCount  = 8,
    parameter int unsigned DataWidth = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    rom_ctrl_check_fsm_if.master  bus
);
    localparam int unsigned AW       = (RomDepth > 1) ? $clog2(RomDepth) : 1;
    localparam int unsigned TAW      = (TopCount > 1) ? $clog2(TopCount) : 1;
    localparam int unsigned TopStart = RomDepth - TopCount;
    localparam logic [AW-1:0]  AddrTopStart = AW'(TopStart);
    localparam logic [AW-1:0]  AddrLast     = AW'(RomDepth - 1);
    localparam logic [TAW-1:0] IdxLast      = TAW'(TopCount - 1);

    typedef enum logic [5:0] {
        StReadLow  = 6'b001011,
        StReadTop  = 6'b010110,
        StWaitKmac = 6'b101100,
        StCompare  = 6'b110001,
        StDone     = 6'b011101,
        StInvalid  = 6'b100010
    } state_e;

    state_e               state_q;
    logic                 req_q, pending_q, rd_low_q, vld_q, last_q, cap_vld_q;
    logic                 kmac_seen_q, mismatch_q, done_q, good_q, bus_sel_q, alert_q;
    logic [AW-1:0]        addr_q;
    logic [TAW-1:0]       cap_idx_q, cmp_idx_q;
    logic [DataWidth-1:0] data_q;
    logic [7:0]           count_q;
    logic [DataWidth-1:0] exp_digest_q  [TopCount];
    logic [DataWidth-1:0] kmac_digest_q [TopCount];

    logic handshake, cap_last, word_mismatch, fatal;

    assign handshake     = vld_q & bus.kmac_rom_rdy;
    assign cap_last      = cap_vld_q && (cap_idx_q == IdxLast);
    assign word_mismatch = exp_digest_q[cmp_idx_q] != kmac_digest_q[cmp_idx_q];

    always_comb begin
        fatal = 1'b0;
        case (state_q)
            StReadLow:             fatal = bus.kmac_done;
            StReadTop, StWaitKmac: fatal = bus.kmac_done & bus.kmac_err;
            StCompare:             fatal = bus.kmac_done;
            // Done must hold the address still; any movement is treated as a fault.
            StDone:                fatal = bus.kmac_done | (addr_q != AddrLast);
            default:               fatal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StReadLow;
            req_q       <= 1'b0;
            pending_q   <= 1'b0;
            rd_low_q    <= 1'b0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
            cap_vld_q   <= 1'b0;
            kmac_seen_q <= 1'b0;
            mismatch_q  <= 1'b0;
            done_q      <= 1'b0;
            good_q      <= 1'b0;
            bus_sel_q   <= 1'b0;
            alert_q     <= 1'b0;
            addr_q      <= '0;
            cap_idx_q   <= '0;
            cmp_idx_q   <= '0;
            data_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(TopCount); i++) begin
                exp_digest_q[i]  <= '0;
                kmac_digest_q[i] <= '0;
            end
        end else begin
            // An open KMAC transfer is always allowed to complete, even after a fault.
            if (handshake) begin
                vld_q     <= 1'b0;
                last_q    <= 1'b0;
                pending_q <= 1'b0;
            end
            if (cap_vld_q) exp_digest_q[cap_idx_q] <= bus.rom_data;
            cap_vld_q <= 1'b0;

            if (fatal) begin
                state_q   <= StInvalid;
                alert_q   <= 1'b1;
                done_q    <= 1'b0;
                good_q    <= 1'b0;
                bus_sel_q <= 1'b0;
                req_q     <= 1'b0;
                rd_low_q  <= 1'b0;
            end else begin
                case (state_q)
                    StReadLow: begin
                        if (req_q) begin
                            req_q     <= 1'b0;
                            pending_q <= 1'b1;
                            rd_low_q  <= 1'b1;
                            addr_q    <= addr_q + AW'(1);
                        end else if (!pending_q) begin
                            req_q <= 1'b1;
                        end
                        if (rd_low_q) begin
                            rd_low_q <= 1'b0;
                            data_q   <= bus.rom_data;
                            vld_q    <= 1'b1;
                            last_q   <= (addr_q == AddrTopStart);
                        end
                        if (handshake) begin
                            req_q <= 1'b1;
                            if (last_q) state_q <= StReadTop;
                        end
                    end
                    StReadTop: begin
                        if (req_q) begin
                            cap_vld_q <= 1'b1;
                            cap_idx_q <= TAW'(addr_q - AddrTopStart);
                            if (addr_q == AddrLast) req_q  <= 1'b0;
                            else                    addr_q <= addr_q + AW'(1);
                        end
                        if (bus.kmac_done) begin
                            kmac_seen_q <= 1'b1;
                            for (int i = 0; i < int'(TopCount); i++) begin
                                kmac_digest_q[i] <= bus.kmac_digest[i*DataWidth +: DataWidth];
                            end
                        end
                        if (cap_last) begin
                            state_q <= (kmac_seen_q || bus.kmac_done) ? StCompare : StWaitKmac;
                        end
                    end
                    StWaitKmac: begin
                        if (bus.kmac_done) begin
                            kmac_seen_q <= 1'b1;
                            state_q     <= StCompare;
                            for (int i = 0; i < int'(TopCount); i++) begin
                                kmac_digest_q[i] <= bus.kmac_digest[i*DataWidth +: DataWidth];
                            end
                        end
                    end
                    StCompare: begin
                        mismatch_q <= mismatch_q | word_mismatch;
                        if (cmp_idx_q == IdxLast) begin
                            state_q   <= StDone;
                            cmp_idx_q <= '0;
                            done_q    <= 1'b1;
                            bus_sel_q <= 1'b1;
                            good_q    <= !(mismatch_q | word_mismatch);
                            count_q   <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        end else begin
                            cmp_idx_q <= cmp_idx_q + TAW'(1);
                        end
                    end
`ifdef ROM_CTRL_CHECK_RECHECK_EN
                    StDone: begin
                        if (bus.recheck_req) begin
                            state_q     <= StReadLow;
                            done_q      <= 1'b0;
                            good_q      <= 1'b0;
                            bus_sel_q   <= 1'b0;
                            kmac_seen_q <= 1'b0;
                            mismatch_q  <= 1'b0;
                            addr_q      <= '0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifndef ROM_CTRL_CHECK_RECHECK_EN
    logic unused_recheck_req;
    assign unused_recheck_req = bus.recheck_req;
`endif

    assign bus.rom_req       = req_q;
    assign bus.rom_addr      = addr_q;
    assign bus.kmac_rom_vld  = vld_q;
    assign bus.kmac_rom_data = data_q;
    assign bus.kmac_rom_last = vld_q & last_q;
    assign bus.bus_sel       = bus_sel_q;
    assign bus.done          = done_q;
    assign bus.good          = good_q;
    assign bus.check_count   = count_q;
    assign bus.alert         = alert_q;
endmodule
